// File: rtl/memory_port_arbiter.sv
// Two-master arbiter (CPU = master 0, I/O channel = master 1) in front of the single
// Memory port; grants one master per cycle with hold-time fairness and lock support.
module memory_port_arbiter #(
  parameter int MAX_HOLD        = 8,
  parameter int PRIORITY_MASTER = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [0:1]    running,
  input  logic [0:1]    lock,
  input  logic [15:31]  address0,
  input  logic [15:31]  address1,
  input  logic [0:3]    write_en0,
  input  logic [0:3]    write_en1,
  input  logic [0:31]   data_in0,
  input  logic [0:31]   data_in1,
  output logic [0:1]    active,
  output logic [15:31]  mem_address,
  output logic [0:3]    mem_write_en,
  output logic [0:31]   mem_data_in
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic LAST_RESET = (PRIORITY_MASTER == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              last_owner_q, last_owner_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      last_owner_q <= LAST_RESET;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    last_owner_d = last_owner_q;

    case (state_q)
      IDLE: begin
        if (running[0] && running[1])
          state_d = last_owner_q ? OWN0 : OWN1;
        else if (running[0])
          state_d = OWN0;
        else if (running[1])
          state_d = OWN1;
      end
      OWN0: begin
        if (!running[0])
          state_d = running[1] ? OWN1 : IDLE;
        else if (running[1] && !lock[0] && hold_q >= HOLD_LAST)
          state_d = OWN1;
      end
      OWN1: begin
        if (!running[1])
          state_d = running[0] ? OWN0 : IDLE;
        else if (running[0] && !lock[1] && hold_q >= HOLD_LAST)
          state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase

    // Hold saturates (rather than wrapping) so a locked owner switches on the edge after unlock.
    if (state_d != state_q) begin
      hold_d = '0;
      if (state_q == OWN0)
        last_owner_d = 1'b0;
      else if (state_q == OWN1)
        last_owner_d = 1'b1;
    end else if (state_q != IDLE && hold_q < HOLD_SAT) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_comb begin
    active       = 2'b00;
    mem_address  = '0;
    mem_write_en = '0;
    mem_data_in  = '0;
    case (state_q)
      OWN0: begin
        active       = 2'b10;
        mem_address  = address0;
        mem_write_en = write_en0;
        mem_data_in  = data_in0;
      end
      OWN1: begin
        active       = 2'b01;
        mem_address  = address1;
        mem_write_en = write_en1;
        mem_data_in  = data_in1;
      end
      default: ;
    endcase
    // Writes must be blocked even in the cycle reset is first seen, before state returns to IDLE.
    if (!reset)
      mem_write_en = '0;
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: per-cycle vector table plus directed
// sequences for hold rotation, lock, write dropping, handoff and mid-burst reset.
module tb_memory_port_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [0:1]   running, lock;
  logic [15:31] address0, address1;
  logic [0:3]   write_en0, write_en1;
  logic [0:31]  data_in0, data_in1;

  logic [0:1]   active, active_b;
  logic [15:31] mem_address, mem_address_b;
  logic [0:3]   mem_write_en, mem_write_en_b;
  logic [0:31]  mem_data_in, mem_data_in_b;

  logic [0:31]  mem [0:255];

  int total_checks  = 0;
  int passed_checks = 0;

  always #5 clock = ~clock;

  memory_port_arbiter #(.MAX_HOLD(8), .PRIORITY_MASTER(0)) dut (
    .clock(clock), .reset(reset), .running(running), .lock(lock),
    .address0(address0), .address1(address1),
    .write_en0(write_en0), .write_en1(write_en1),
    .data_in0(data_in0), .data_in1(data_in1),
    .active(active), .mem_address(mem_address),
    .mem_write_en(mem_write_en), .mem_data_in(mem_data_in)
  );

  // Second instance exercises the single-cycle-hold corner with master 1 as reset priority.
  memory_port_arbiter #(.MAX_HOLD(1), .PRIORITY_MASTER(1)) dut_b (
    .clock(clock), .reset(reset), .running(running), .lock(lock),
    .address0(address0), .address1(address1),
    .write_en0(write_en0), .write_en1(write_en1),
    .data_in0(data_in0), .data_in1(data_in1),
    .active(active_b), .mem_address(mem_address_b),
    .mem_write_en(mem_write_en_b), .mem_data_in(mem_data_in_b)
  );

  // Word-addressed memory with byte lanes, driven by the main instance only.
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (mem_write_en[i])
        mem[mem_address[24:31]][8*i +: 8] <= mem_data_in[8*i +: 8];
  end

  typedef struct {
    logic         rst_n;
    logic [0:1]   run;
    logic [0:1]   lck;
    logic [0:1]   exp_active;
    logic [15:31] exp_addr;
    logic [0:3]   exp_we;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_n, input logic [0:1] run, input logic [0:1] lck);
    reset   = rst_n;
    running = run;
    lock    = lck;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected)
      passed_checks++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 2'b00, 2'b00);
    step();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset     = 1'b0;
    running   = 2'b00;
    lock      = 2'b00;
    address0  = 17'h00040;
    address1  = 17'h00050;
    write_en0 = 4'b1100;
    write_en1 = 4'b0011;
    data_in0  = 32'h11111111;
    data_in1  = 32'h22222222;

    vecs[0]  = '{1'b0, 2'b00, 2'b00, 2'b00, 17'h0,     4'b0000};
    vecs[1]  = '{1'b0, 2'b10, 2'b00, 2'b00, 17'h0,     4'b0000};
    vecs[2]  = '{1'b1, 2'b10, 2'b00, 2'b10, 17'h00040, 4'b1100};
    vecs[3]  = '{1'b1, 2'b00, 2'b00, 2'b00, 17'h0,     4'b0000};
    vecs[4]  = '{1'b1, 2'b11, 2'b00, 2'b01, 17'h00050, 4'b0011};
    vecs[5]  = '{1'b1, 2'b10, 2'b00, 2'b10, 17'h00040, 4'b1100};
    vecs[6]  = '{1'b1, 2'b01, 2'b00, 2'b01, 17'h00050, 4'b0011};
    vecs[7]  = '{1'b1, 2'b00, 2'b00, 2'b00, 17'h0,     4'b0000};
    vecs[8]  = '{1'b1, 2'b11, 2'b00, 2'b10, 17'h00040, 4'b1100};
    vecs[9]  = '{1'b1, 2'b00, 2'b11, 2'b00, 17'h0,     4'b0000};
    vecs[10] = '{1'b1, 2'b01, 2'b10, 2'b01, 17'h00050, 4'b0011};
    vecs[11] = '{1'b0, 2'b01, 2'b00, 2'b00, 17'h0,     4'b0000};

    // Vector table: reset behaviour, IDLE arbitration, direct handoff, lock without running.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].run, vecs[i].lck);
      step();
      checkOutput($sformatf("vec%0d_active", i), 32'(active), 32'(vecs[i].exp_active));
      checkOutput($sformatf("vec%0d_addr", i), 32'(mem_address), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("vec%0d_we", i), 32'(mem_write_en), 32'(vecs[i].exp_we));
    end

    // Both requesting from reset: main alternates every 8 cycles, MAX_HOLD=1 alternates every cycle.
    write_en0 = 4'b0000;
    write_en1 = 4'b0101;
    address1  = 17'h00077;
    data_in1  = 32'hCAFEF00D;
    applyStimulus(1'b0, 2'b11, 2'b00);
    step();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      checkOutput($sformatf("rot_active_c%0d", i), 32'(active),
                  32'(((i / 8) % 2 == 0) ? 2'b10 : 2'b01));
      checkOutput($sformatf("hold1_active_c%0d", i), 32'(active_b),
                  32'(((i % 2) == 0) ? 2'b01 : 2'b10));
      if (i == 0) begin
        checkOutput("hold1_addr", 32'(mem_address_b), 32'h00077);
        checkOutput("hold1_we", 32'(mem_write_en_b), 32'h5);
        checkOutput("hold1_data", 32'(mem_data_in_b), 32'hCAFEF00D);
      end
    end

    // Locked owner keeps the port past MAX_HOLD; switch on the edge after unlock.
    write_en1 = 4'b0000;
    doReset();
    applyStimulus(1'b1, 2'b11, 2'b10);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput($sformatf("lock_active_c%0d", i), 32'(active), 32'(2'b10));
    end
    checkOutput("lock_hold_sat", 32'(dut.hold_q), 32'd8);
    lock = 2'b00;
    step();
    checkOutput("unlock_switch", 32'(active), 32'(2'b01));

    // Non-granted master 1 write is dropped.
    doReset();
    address0  = 17'h00010;
    address1  = 17'h00010;
    data_in1  = 32'hDEADBEEF;
    write_en1 = 4'hF;
    running   = 2'b10;
    step();
    running = 2'b11;
    for (int i = 0; i < 3; i++) step();
    checkOutput("drop_active", 32'(active), 32'(2'b10));
    checkOutput("drop_mem10", mem[8'h10], 32'h0);
    running   = 2'b00;
    write_en1 = 4'h0;
    step();

    // Owner drops while other raises in the same cycle: direct handoff, then write lands.
    running = 2'b10;
    step();
    running   = 2'b01;
    address1  = 17'h00020;
    data_in1  = 32'h12345678;
    write_en1 = 4'hF;
    step();
    checkOutput("handoff_active", 32'(active), 32'(2'b01));
    checkOutput("handoff_addr", 32'(mem_address), 32'h00020);
    step();
    running   = 2'b00;
    write_en1 = 4'h0;
    step();
    checkOutput("handoff_mem20", mem[8'h20], 32'h12345678);

    // Reset arriving mid-burst blocks the write combinationally and returns to IDLE.
    address0  = 17'h00030;
    data_in0  = 32'hA5A5A5A5;
    write_en0 = 4'h0;
    running   = 2'b10;
    step();
    checkOutput("burst_active", 32'(active), 32'(2'b10));
    reset     = 1'b0;
    write_en0 = 4'hF;
    #1;
    checkOutput("rst_we_forced", 32'(mem_write_en), 32'h0);
    step();
    checkOutput("rst_idle_active", 32'(active), 32'(2'b00));
    checkOutput("rst_mem30", mem[8'h30], 32'h0);
    applyStimulus(1'b1, 2'b00, 2'b00);
    write_en0 = 4'h0;
    step();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
